dev_bus_router: RTL and testbench

- Single-master request router between the core's load/store port and the device set enumerated by did_t (RAM, ROM, MAT, INT, REG, EXE, SPI).
- Decodes each request address into a device ID and forwards the request over a shared request bus with a per-device valid strobe.
- Collects the selected device's response and returns it to the master with an error flag.
- Handles one transaction in flight at a time, with a per-transaction timeout.

---
 rtl/dev_bus_router_pkg.sv | 33 +++
 rtl/dev_bus_router.sv | 152 +++++++++++++++
 tb/tb_dev_bus_router.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/dev_bus_router_pkg.sv
// Shared types and address-decode helpers for the device bus router.
// The top three address bits select one of eight 8 KiB device regions.
package dev_bus_router_pkg;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 256;
    localparam int NUM_DEV     = 8;
    localparam int DEV_SEL_MSB = ADDR_W - 1;
    localparam int DEV_SEL_LSB = ADDR_W - 3;

    typedef enum logic [2:0] {
        DRAM = 3'd0,
        DROM = 3'd1,
        DMAT = 3'd2,
        DINT = 3'd3,
        DREG = 3'd4,
        DEXE = 3'd5,
        DSPI = 3'd6,
        DNON = 3'd7
    } did_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } rtr_state_t;

    function automatic did_t dev_of_addr(input logic [ADDR_W-1:0] addr);
        return did_t'(addr[DEV_SEL_MSB:DEV_SEL_LSB]);
    endfunction

endpackage

// File: rtl/dev_bus_router.sv
// Single-master router: decodes a request to one device, issues it on a shared
// bus with a one-hot strobe, and returns the response or a decode/timeout error.
module dev_bus_router
    import dev_bus_router_pkg::*;
#(
    parameter int ADDR_W      = dev_bus_router_pkg::ADDR_W,
    parameter int DATA_W      = dev_bus_router_pkg::DATA_W,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic                      req_we,
    input  logic [DATA_W-1:0]         req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [NUM_DEV-1:0]        dev_valid,
    input  logic [NUM_DEV-1:0]        dev_ready,
    output logic [ADDR_W-1:0]         dev_addr,
    output logic                      dev_we,
    output logic [DATA_W-1:0]         dev_wdata,
    input  logic [NUM_DEV-1:0]        dev_rvalid,
    input  logic [NUM_DEV*DATA_W-1:0] dev_rdata,
    output logic                      busy
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] TMO_LAST =
        CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    rtr_state_t          state_q;
    did_t                did_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [NUM_DEV-1:0]  dev_valid_q;
    logic [ADDR_W-1:0]   dev_addr_q;
    logic                dev_we_q;
    logic [DATA_W-1:0]   dev_wdata_q;
    logic                rsp_valid_q;
    logic                rsp_err_q;
    logic [DATA_W-1:0]   rsp_rdata_q;

    logic [2:0]          sel;
    logic                sel_rdy;
    logic                sel_rv;
    logic [DATA_W-1:0]   sel_data;
    logic                tmo_hit;
    logic [CNT_W-1:0]    cnt_inc;
    did_t                req_did;

    assign sel      = did_q;
    assign sel_rdy  = dev_ready[sel];
    assign sel_rv   = dev_rvalid[sel];
    assign sel_data = dev_rdata[int'(sel)*DATA_W +: DATA_W];
    assign req_did  = dev_of_addr(req_addr);

    // The current cycle counts toward the limit, so the check uses the pre-increment value.
    assign tmo_hit  = (TIMEOUT_CYC != 0) && (cnt_q >= TMO_LAST);
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign dev_valid = dev_valid_q;
    assign dev_addr  = dev_addr_q;
    assign dev_we    = dev_we_q;
    assign dev_wdata = dev_wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            did_q       <= DRAM;
            cnt_q       <= '0;
            dev_valid_q <= '0;
            dev_addr_q  <= '0;
            dev_we_q    <= 1'b0;
            dev_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        dev_addr_q  <= req_addr;
                        dev_we_q    <= req_we;
                        dev_wdata_q <= req_wdata;
                        did_q       <= req_did;
                        cnt_q       <= '0;
                        if (req_did == DNON) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            state_q     <= ISSUE;
                            dev_valid_q <= NUM_DEV'(1) << req_did;
                        end
                    end
                end
                ISSUE: begin
                    cnt_q <= cnt_inc;
                    if (sel_rdy && sel_rv) begin
                        state_q     <= RESP;
                        dev_valid_q <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= dev_we_q ? '0 : sel_data;
                    end else if (tmo_hit) begin
                        state_q     <= RESP;
                        dev_valid_q <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end else if (sel_rdy) begin
                        state_q     <= WAIT;
                        dev_valid_q <= '0;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_inc;
                    if (sel_rv) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= dev_we_q ? '0 : sel_data;
                    end else if (tmo_hit) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dev_bus_router.sv
// Directed and randomized transactions against a delay-based outcome model of the router.
module tb_dev_bus_router;

    localparam int AW  = 16;
    localparam int DW  = 256;
    localparam int ND  = 8;
    localparam int TMO = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [AW-1:0]    req_addr;
    logic             req_we;
    logic [DW-1:0]    req_wdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [DW-1:0]    rsp_rdata;
    logic             rsp_err;
    logic [ND-1:0]    dev_valid;
    logic [ND-1:0]    dev_ready;
    logic [AW-1:0]    dev_addr;
    logic             dev_we;
    logic [DW-1:0]    dev_wdata;
    logic [ND-1:0]    dev_rvalid;
    logic [ND*DW-1:0] dev_rdata;
    logic             busy;

    logic [DW-1:0]    rd_arr [ND];
    int               n_cmp = 0;
    int               n_bad = 0;

    always #5 clk = ~clk;

    always_comb begin
        dev_rdata = '0;
        for (int i = 0; i < ND; i++) dev_rdata[i*DW +: DW] = rd_arr[i];
    end

    dev_bus_router #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .dev_valid(dev_valid), .dev_ready(dev_ready), .dev_addr(dev_addr),
        .dev_we(dev_we), .dev_wdata(dev_wdata),
        .dev_rvalid(dev_rvalid), .dev_rdata(dev_rdata), .busy(busy)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand256();
        logic [DW-1:0] v;
        for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Random activity on every device except the selected one, whose bits are forced.
    task automatic drive_dev(input int sel, input bit rdy, input bit rv);
        logic [ND-1:0] m;
        m          = ND'(1) << sel;
        dev_ready  = (ND'($urandom) & ~m) | (rdy ? m : '0);
        dev_rvalid = (ND'($urandom) & ~m) | (rv ? m : '0);
    endtask

    // One transaction: device raises ready rdy_dly cycles into the strobe and
    // rvalid rv_dly cycles after that; the outcome follows from the timeout budget.
    task automatic do_txn(input logic [AW-1:0] addr, input logic we, input logic [DW-1:0] wd,
                          input logic [DW-1:0] rd, input int rdy_dly, input int rv_dly,
                          input int hold);
        int sel, krdy, kr, kend, kstrobe;
        logic err_e;
        logic [DW-1:0] rd_e;
        sel  = int'(addr[AW-1:AW-3]);
        krdy = rdy_dly + 1;
        kr   = krdy + rv_dly;
        rd_arr[sel] = rd;
        if (sel == 7) begin
            err_e = 1'b1; rd_e = '0; kend = 0;
        end else if (kr <= TMO) begin
            err_e = 1'b0; rd_e = we ? '0 : rd; kend = kr;
        end else begin
            err_e = 1'b1; rd_e = '0; kend = TMO;
        end
        kstrobe = (krdy < kend) ? krdy : kend;

        @(negedge clk);
        chk("idle_req_ready", DW'(req_ready), DW'(1));
        chk("idle_rsp_valid", DW'(rsp_valid), DW'(0));
        req_valid = 1'b1; req_addr = addr; req_we = we; req_wdata = wd;
        drive_dev(sel, 1'b0, 1'b0);

        for (int k = 1; k <= kend; k++) begin
            @(negedge clk);
            chk("dev_valid", DW'(dev_valid), (k <= kstrobe) ? DW'(ND'(1) << sel) : DW'(0));
            chk("busy_rsp_valid", DW'(rsp_valid), DW'(0));
            chk("busy", DW'(busy), DW'(1));
            if (k == 1) begin
                chk("dev_addr", DW'(dev_addr), DW'(addr));
                chk("dev_we", DW'(dev_we), DW'(we));
                chk("dev_wdata", dev_wdata, wd);
            end
            req_valid = 1'($urandom); req_addr = AW'($urandom); req_we = 1'($urandom);
            req_wdata = rand256();
            drive_dev(sel, k >= krdy, k == kr);
        end

        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            chk("rsp_valid", DW'(rsp_valid), DW'(1));
            chk("rsp_err", DW'(rsp_err), DW'(err_e));
            chk("rsp_rdata", rsp_rdata, rd_e);
            chk("resp_req_ready", DW'(req_ready), DW'(0));
            chk("resp_dev_valid", DW'(dev_valid), DW'(0));
            req_valid = 1'b1; req_addr = AW'($urandom);
            rsp_ready = (h == hold);
            drive_dev(sel, 1'b0, 1'b0);
        end

        @(negedge clk);
        chk("post_busy", DW'(busy), DW'(0));
        chk("post_rsp_valid", DW'(rsp_valid), DW'(0));
        req_valid = 1'b0; rsp_ready = 1'b0;
        drive_dev(sel, 1'b0, 1'b0);
    endtask

    // Idle cycles with a stray response from device pulse_dev on the third one.
    task automatic idle_cycles(input int pulse_dev);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_busy", DW'(busy), DW'(0));
            chk("idle_no_rsp", DW'(rsp_valid), DW'(0));
            dev_ready  = '0;
            dev_rvalid = (i == 2) ? ND'(1) << pulse_dev : '0;
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_wdata = '0;
        rsp_ready = 1'b0; dev_ready = '0; dev_rvalid = '0;
        for (int i = 0; i < ND; i++) rd_arr[i] = '0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", DW'(req_ready), DW'(1));
        chk("rst_rsp_valid", DW'(rsp_valid), DW'(0));
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_dev_valid", DW'(dev_valid), DW'(0));
        chk("rst_dev_addr", DW'(dev_addr), DW'(0));
        rst = 1'b0;

        do_txn(16'h0040, 1'b0, rand256(), {32{8'hA5}}, 0, 2, 0);
        do_txn(16'hC010, 1'b1, DW'(16'h1234), rand256(), 0, 0, 0);
        do_txn(16'hE000, 1'b0, rand256(), rand256(), 0, 0, 0);
        do_txn(16'h2000, 1'b0, rand256(), rand256(), 100, 0, 0);
        idle_cycles(1);
        do_txn(16'h8123, 1'b0, rand256(), rand256(), 1, 1, 5);
        do_txn(16'h6004, 1'b0, rand256(), rand256(), 3, 0, 1);
        do_txn(16'hA010, 1'b0, rand256(), rand256(), 3, 1, 0);

        // Reset during WAIT of a DMAT read, then a stale response arrives.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 16'h4000; req_we = 1'b0; dev_ready = '0; dev_rvalid = '0;
        @(negedge clk);
        req_valid = 1'b0; dev_ready = ND'(1) << 2;
        @(negedge clk);
        chk("wait_busy", DW'(busy), DW'(1));
        chk("wait_dev_valid", DW'(dev_valid), DW'(0));
        dev_ready = '0; rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", DW'(busy), DW'(0));
        chk("mid_rst_req_ready", DW'(req_ready), DW'(1));
        chk("mid_rst_rsp_valid", DW'(rsp_valid), DW'(0));
        chk("mid_rst_dev_valid", DW'(dev_valid), DW'(0));
        chk("mid_rst_dev_addr", DW'(dev_addr), DW'(0));
        chk("mid_rst_dev_we", DW'(dev_we), DW'(0));
        chk("mid_rst_dev_wdata", dev_wdata, DW'(0));
        chk("mid_rst_rsp_err", DW'(rsp_err), DW'(0));
        chk("mid_rst_rsp_rdata", rsp_rdata, DW'(0));
        rst = 1'b0; dev_rvalid = ND'(1) << 2;
        @(negedge clk);
        chk("stale_rsp_valid", DW'(rsp_valid), DW'(0));
        chk("stale_busy", DW'(busy), DW'(0));
        dev_rvalid = '0;

        for (int t = 0; t < 30; t++) begin
            do_txn(AW'($urandom), 1'($urandom), rand256(), rand256(),
                   int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                   int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
